// File: rtl/capture_reader.sv
// Purpose : reads a circular capture RAM back oldest-sample-first and streams it out on a valid/ready port.
// Latency : first out_valid two clock edges after the edge that samples start; then one word per cycle.
// Backpressure: out_ready low stalls the stream; reads are throttled so a 2-entry buffer never overflows.
// Optional: define CAPTURE_READER_CHECKSUM_EN to append an XOR checksum word after the data words.
module capture_reader #(
   parameter int DATA_WIDTH = 19,
   parameter int BUF_DEPTH  = 1024
) (
   input  logic                  cfg_clk,
   input  logic                  cfg_rstn,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  stop_flag,
   input  logic [15:0]           stop_addr,
   input  logic [15:0]           rd_len,
   output logic                  rd_ce,
   output logic [15:0]           rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [1:0]  IDLE   = 2'd0;
   localparam logic [1:0]  READ   = 2'd1;
   localparam logic [1:0]  DRAIN  = 2'd2;
   localparam logic [1:0]  FINISH = 2'd3;

   localparam logic [15:0] ADDR_MASK = 16'(BUF_DEPTH - 1);
   localparam logic [17:0] DEPTH_W   = 18'(BUF_DEPTH);
`ifdef CAPTURE_READER_CHECKSUM_EN
   // The checksum travels through the pipeline as one extra read slot.
   localparam logic [17:0] EXTRA_SLOTS = 18'd1;
`else
   localparam logic [17:0] EXTRA_SLOTS = 18'd0;
`endif

   // Reset is asserted asynchronously but released on a clock edge.
   logic [1:0] rst_sync;
   logic       core_rstn;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [17:0] slots_left;
   logic [15:0] rd_addr_q;
   logic        infl_vld;
   logic        infl_last;
   logic        err_q;

   logic [1:0][DATA_WIDTH-1:0] buf_dat;
   logic [1:0]                 buf_last;
   logic                       wr_ptr;
   logic                       rd_ptr;
   logic [1:0]                 buf_cnt;

   logic                  push;
   logic                  pop;
   logic [2:0]            committed;
   logic                  issue;
   logic                  last_slot;
   logic                  csum_slot;
   logic                  start_ok;
   logic [17:0]           len_w;
   logic [17:0]           word_cnt;
   logic [17:0]           total_slots;
   logic [DATA_WIDTH-1:0] push_dat;

`ifdef CAPTURE_READER_CHECKSUM_EN
   logic                  infl_csum;
   logic [DATA_WIDTH-1:0] csum_q;
`endif

   // Two-flop release synchroniser for the internal reset.
   always_ff @(posedge cfg_clk or negedge cfg_rstn) begin
      if (!cfg_rstn) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign core_rstn = rst_sync[1];

   assign push      = infl_vld;
   assign pop       = (buf_cnt != 2'd0) && out_ready;
   // Entries that will be held after this cycle's pop, plus the read already on its way.
   // Counting the pop lets a read issue alongside a transfer, giving 1 word/cycle.
   assign committed = {1'b0, buf_cnt} - {2'b00, pop} + {2'b00, infl_vld};
   assign last_slot = (slots_left == 18'd1);
   assign issue     = (state == READ) && (slots_left != 18'd0) && (committed < 3'd2);
`ifdef CAPTURE_READER_CHECKSUM_EN
   assign csum_slot = last_slot;
   assign push_dat  = infl_csum ? csum_q : rd_data;
`else
   assign csum_slot = 1'b0;
   assign push_dat  = rd_data;
`endif
   assign rd_ce     = issue && !csum_slot;

   assign start_ok    = (state == IDLE) && start && !abort && stop_flag;
   assign len_w       = {2'b00, rd_len};
   assign word_cnt    = (len_w > DEPTH_W) ? DEPTH_W : len_w;
   assign total_slots = word_cnt + EXTRA_SLOTS;

   // Next-state logic; abort overrides everything, including a same-cycle start.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = (total_slots == 18'd0) ? FINISH : READ;
            end
         end
         READ: begin
            if (issue && last_slot) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && out_last) begin
               state_nxt = FINISH;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   // FSM, read address generator and the in-flight read tracker.
   always_ff @(posedge cfg_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state      <= IDLE;
         slots_left <= 18'd0;
         rd_addr_q  <= 16'd0;
         infl_vld   <= 1'b0;
         infl_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (abort) begin
            // Any read still returning from the RAM is discarded.
            slots_left <= 18'd0;
            infl_vld   <= 1'b0;
            infl_last  <= 1'b0;
         end else if (start_ok) begin
            // Oldest sample sits just after the last written address.
            rd_addr_q  <= (stop_addr + 16'd1) & ADDR_MASK;
            slots_left <= total_slots;
            infl_vld   <= 1'b0;
            infl_last  <= 1'b0;
         end else begin
            infl_vld  <= issue;
            infl_last <= issue && last_slot;
            if (rd_ce) begin
               rd_addr_q <= (rd_addr_q + 16'd1) & ADDR_MASK;
            end
            if (issue) begin
               slots_left <= slots_left - 18'd1;
            end
         end
      end
   end

   // Two-entry output buffer fed by the returning reads.
   always_ff @(posedge cfg_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         buf_dat  <= '0;
         buf_last <= 2'b00;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         buf_cnt  <= 2'd0;
      end else if (abort) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         buf_cnt <= 2'd0;
      end else begin
         if (push) begin
            buf_dat[wr_ptr]  <= push_dat;
            buf_last[wr_ptr] <= infl_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Illegal start: readback requested before the trigger has stopped capture.
   always_ff @(posedge cfg_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (state == IDLE) && start && !abort && !stop_flag;
      end
   end

`ifdef CAPTURE_READER_CHECKSUM_EN
   // Running XOR of every data word entering the buffer; tag marks the checksum slot.
   always_ff @(posedge cfg_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         csum_q    <= '0;
         infl_csum <= 1'b0;
      end else begin
         infl_csum <= !abort && !start_ok && issue && csum_slot;
         if (start_ok) begin
            csum_q <= '0;
         end else if (push && !infl_csum) begin
            csum_q <= csum_q ^ rd_data;
         end
      end
   end
`endif

   assign rd_addr   = rd_addr_q;
   assign out_valid = (buf_cnt != 2'd0);
   assign out_data  = buf_dat[rd_ptr];
   assign out_last  = out_valid && buf_last[rd_ptr];
   assign busy      = (state != IDLE);
   assign done      = (state == FINISH) && !abort;
   assign err       = err_q;

endmodule
